// File: rtl/mlaccel_qpi_link.sv
// QPI slave front-end: oversamples the host SPI/dual/quad bus in the system clock domain,
// deserialises into an RX FIFO, serialises responses from a TX FIFO, and drives rdy/err status.
module mlaccel_qpi_link #(
  parameter int LANES       = 4,
  parameter int RX_DEPTH    = 8,
  parameter int TX_DEPTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        qpi_csb_di,
  input  logic                        qpi_clk_di,
  input  logic [LANES-1:0]            qpi_io_di,
  output logic [LANES-1:0]            qpi_io_do,
  output logic [LANES-1:0]            qpi_io_oe,
  output logic                        qpi_rdy_do,
  output logic                        qpi_err_do,
  output logic                        din_valid,
  input  logic                        din_ready,
  output logic                        din_start,
  output logic [7:0]                  din_data,
  input  logic                        dout_valid,
  output logic                        dout_ready,
  input  logic [7:0]                  dout_data,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);

  localparam int RXAW = $clog2(RX_DEPTH);
  localparam int TXAW = $clog2(TX_DEPTH);
  localparam logic [RXAW:0] RX_FULL_LVL = (RXAW+1)'(RX_DEPTH);
  localparam logic [RXAW:0] RX_RDY_MAX  = (RXAW+1)'(RX_DEPTH - 2);
  localparam logic [TXAW:0] TX_FULL_LVL = (TXAW+1)'(TX_DEPTH);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mlaccel_qpi_link: LANES must be 1, 2 or 4");
  end
  if (SYNC_STAGES < 2 || RX_DEPTH < 4 || TX_DEPTH < 2) begin : g_bad_depth
    $error("mlaccel_qpi_link: SYNC_STAGES/RX_DEPTH/TX_DEPTH out of range");
  end

  logic [SYNC_STAGES-1:0] csb_sync, clk_sync, prime_sr;
  logic [LANES-1:0]       io_sync [SYNC_STAGES-1];

  // io only needs to reach the stage that carries the new clk value
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= '1;
      clk_sync <= '0;
      prime_sr <= '0;
      for (int i = 0; i < SYNC_STAGES-1; i++) io_sync[i] <= '0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], qpi_csb_di};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], qpi_clk_di};
      prime_sr <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
      io_sync[0] <= qpi_io_di;
      for (int i = 1; i < SYNC_STAGES-1; i++) io_sync[i] <= io_sync[i-1];
    end
  end

  logic             csb_s, clk_rise, clk_fall, latched_reset, selected;
  logic [LANES-1:0] io_s;

  assign csb_s    = csb_sync[SYNC_STAGES-1];
  assign clk_rise = clk_sync[SYNC_STAGES-2] & ~clk_sync[SYNC_STAGES-1];
  assign clk_fall = ~clk_sync[SYNC_STAGES-2] & clk_sync[SYNC_STAGES-1];
  assign io_s     = io_sync[SYNC_STAGES-2];
  assign selected = ~csb_s & ~latched_reset;

  // The reset value of the csb synchroniser is not a real sample, so wait until it has flushed
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) latched_reset <= 1'b1;
    else if (prime_sr[SYNC_STAGES-1] && csb_s) latched_reset <= 1'b0;
  end

  logic [2:0] bit_cnt, cnt_next;
  logic       first;
  logic [7:0] rx_sr, rx_sr_next;
  logic       rx_push;

  assign cnt_next   = bit_cnt + 3'(LANES);
  assign rx_sr_next = {rx_sr[7-LANES:0], io_s};
  assign rx_push    = selected && clk_rise && (cnt_next == 3'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt <= '0;
      first   <= 1'b1;
      rx_sr   <= '0;
    end else if (!selected) begin
      bit_cnt <= '0;
      first   <= 1'b1;
      rx_sr   <= '0;
    end else if (clk_rise) begin
      rx_sr   <= rx_sr_next;
      bit_cnt <= cnt_next;
      if (cnt_next == 3'd0) first <= 1'b0;
    end
  end

  logic [8:0]    rx_mem [RX_DEPTH];
  logic [RXAW:0] rx_wr, rx_rd, rx_count;
  logic          rx_full, din_pop, rx_accept, rx_overflow;
  logic [8:0]    rx_head;

  assign rx_count    = rx_wr - rx_rd;
  assign rx_full     = (rx_count == RX_FULL_LVL);
  assign din_valid   = (rx_count != '0);
  assign din_pop     = din_valid && din_ready;
  assign rx_accept   = rx_push && (!rx_full || din_pop);
  assign rx_overflow = rx_push && rx_full && !din_pop;
  assign rx_head     = rx_mem[rx_rd[RXAW-1:0]];
  assign din_start   = rx_head[8];
  assign din_data    = rx_head[7:0];
  assign rx_level    = rx_count;

  // RX contents survive deselect; only reset empties the FIFO
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_wr <= '0;
      rx_rd <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_accept) rx_mem[rx_wr[RXAW-1:0]] <= {first, rx_sr_next};
      rx_wr <= rx_wr + (RXAW+1)'(rx_accept);
      rx_rd <= rx_rd + (RXAW+1)'(din_pop);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      qpi_err_do <= 1'b0;
      qpi_rdy_do <= 1'b0;
    end else begin
      qpi_rdy_do <= selected && (rx_count <= RX_RDY_MAX);
      if (!selected) qpi_err_do <= 1'b0;
      else if (rx_overflow) qpi_err_do <= 1'b1;
    end
  end

  logic [7:0]    tx_mem [TX_DEPTH];
  logic [TXAW:0] tx_wr, tx_rd, tx_count, tx_count_next;
  logic          tx_push, tx_pop, tx_oe;
  logic [7:0]    tx_sr;

  assign tx_count      = tx_wr - tx_rd;
  assign tx_push       = selected && dout_valid && dout_ready;
  assign tx_pop        = selected && clk_fall && (bit_cnt == 3'd0) && (tx_count != '0);
  assign tx_count_next = selected ? tx_count + (TXAW+1)'(tx_push) - (TXAW+1)'(tx_pop) : '0;
  assign tx_level      = tx_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_wr      <= '0;
      tx_rd      <= '0;
      dout_ready <= 1'b0;
      for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      dout_ready <= (tx_count_next != TX_FULL_LVL);
      if (!selected) begin
        tx_wr <= '0;
        tx_rd <= '0;
      end else begin
        if (tx_push) tx_mem[tx_wr[TXAW-1:0]] <= dout_data;
        tx_wr <= tx_wr + (TXAW+1)'(tx_push);
        tx_rd <= tx_rd + (TXAW+1)'(tx_pop);
      end
    end
  end

  // A byte is loaded only at a byte boundary, so io_oe covers whole byte windows
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_sr <= '0;
      tx_oe <= 1'b0;
    end else if (!selected) begin
      tx_sr <= '0;
      tx_oe <= 1'b0;
    end else if (clk_fall) begin
      if (bit_cnt == 3'd0) begin
        if (tx_count != '0) begin
          tx_sr <= tx_mem[tx_rd[TXAW-1:0]];
          tx_oe <= 1'b1;
        end else begin
          tx_sr <= '0;
          tx_oe <= 1'b0;
        end
      end else if (tx_oe) begin
        tx_sr <= tx_sr << LANES;
      end
    end
  end

  assign qpi_io_do = tx_sr[7 -: LANES];
  assign qpi_io_oe = {LANES{tx_oe}};

endmodule

// File: tb/tb_mlaccel_qpi_link.sv
// Directed bench for mlaccel_qpi_link: a quad instance (RX_DEPTH=4) and an SPI instance share
// one host bus; bus edges are slow relative to the system clock.
module tb_mlaccel_qpi_link;

  logic       clock = 1'b0;
  logic       resetn;
  logic       csb, bclk;
  logic [3:0] io;

  logic       q_din_ready, q_dout_valid;
  logic [7:0] q_dout_data;
  logic [3:0] q_io_do, q_io_oe;
  logic       q_rdy, q_err, q_din_valid, q_din_start, q_dout_ready;
  logic [7:0] q_din_data;
  logic [2:0] q_rx_level;
  logic [3:0] q_tx_level;

  logic       s_din_ready, s_dout_valid;
  logic [7:0] s_dout_data;
  logic [0:0] s_io_do, s_io_oe;
  logic       s_rdy, s_err, s_din_valid, s_din_start, s_dout_ready;
  logic [7:0] s_din_data;
  logic [3:0] s_rx_level, s_tx_level;

  logic       s_do_seen, s_oe_seen;
  logic [7:0] pat;
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  mlaccel_qpi_link #(.LANES(4), .RX_DEPTH(4), .TX_DEPTH(8), .SYNC_STAGES(2)) dut_q (
    .clock(clock), .resetn(resetn),
    .qpi_csb_di(csb), .qpi_clk_di(bclk), .qpi_io_di(io),
    .qpi_io_do(q_io_do), .qpi_io_oe(q_io_oe),
    .qpi_rdy_do(q_rdy), .qpi_err_do(q_err),
    .din_valid(q_din_valid), .din_ready(q_din_ready), .din_start(q_din_start), .din_data(q_din_data),
    .dout_valid(q_dout_valid), .dout_ready(q_dout_ready), .dout_data(q_dout_data),
    .rx_level(q_rx_level), .tx_level(q_tx_level)
  );

  mlaccel_qpi_link #(.LANES(1), .RX_DEPTH(8), .TX_DEPTH(8), .SYNC_STAGES(2)) dut_s (
    .clock(clock), .resetn(resetn),
    .qpi_csb_di(csb), .qpi_clk_di(bclk), .qpi_io_di(io[0:0]),
    .qpi_io_do(s_io_do), .qpi_io_oe(s_io_oe),
    .qpi_rdy_do(s_rdy), .qpi_err_do(s_err),
    .din_valid(s_din_valid), .din_ready(s_din_ready), .din_start(s_din_start), .din_data(s_din_data),
    .dout_valid(s_dout_valid), .dout_ready(s_dout_ready), .dout_data(s_dout_data),
    .rx_level(s_rx_level), .tx_level(s_tx_level)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full bus clock period; the SPI pins are sampled just before the rising edge, as a host would
  task automatic apply_stimulus(input logic [3:0] v);
    io = v;
    wait_cycles(3);
    s_do_seen = s_io_do[0];
    s_oe_seen = s_io_oe[0];
    bclk = 1'b1;
    wait_cycles(4);
    bclk = 1'b0;
    wait_cycles(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    apply_stimulus(b[7:4]);
    apply_stimulus(b[3:0]);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp_data, input logic exp_start);
    check_output({tag, "_valid"}, q_din_valid, 1);
    check_output({tag, "_data"}, q_din_data, exp_data);
    check_output({tag, "_start"}, q_din_start, exp_start);
    q_din_ready = 1'b1;
    @(negedge clock);
    q_din_ready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; csb = 1'b1; bclk = 1'b0; io = '0;
    q_din_ready = 1'b0; q_dout_valid = 1'b0; q_dout_data = '0;
    s_din_ready = 1'b1; s_dout_valid = 1'b0; s_dout_data = '0;
    s_do_seen = 1'b0; s_oe_seen = 1'b0;
    wait_cycles(3);
    check_output("rst_rx_level", q_rx_level, 0);
    check_output("rst_tx_level", q_tx_level, 0);
    check_output("rst_din_valid", q_din_valid, 0);
    check_output("rst_dout_ready", q_dout_ready, 0);
    check_output("rst_rdy", q_rdy, 0);
    check_output("rst_err", q_err, 0);
    check_output("rst_io_oe", q_io_oe, 0);
    resetn = 1'b1;
    wait_cycles(5);
    check_output("idle_dout_ready", q_dout_ready, 1);
    check_output("idle_rdy", q_rdy, 0);

    $display("[TB] quad command");
    csb = 1'b0;
    wait_cycles(4);
    check_output("quad_rdy", q_rdy, 1);
    apply_stimulus(4'h2);
    io = 4'h0;
    wait_cycles(3);
    bclk = 1'b1;
    @(negedge clock);
    check_output("quad_lat_early", q_din_valid, 0);
    @(negedge clock);
    check_output("quad_lat_valid", q_din_valid, 1);
    check_output("quad_lat_data", q_din_data, 8'h20);
    wait_cycles(2);
    bclk = 1'b0;
    wait_cycles(4);
    send_byte(8'h15);
    check_output("quad_level2", q_rx_level, 2);
    pop_check("quad_b0", 8'h20, 1'b1);
    pop_check("quad_b1", 8'h15, 1'b0);
    check_output("quad_empty", q_rx_level, 0);
    csb = 1'b1;
    wait_cycles(4);

    $display("[TB] mid-byte deselect");
    csb = 1'b0;
    wait_cycles(4);
    q_dout_data = 8'h77; q_dout_valid = 1'b1;
    @(negedge clock);
    q_dout_valid = 1'b0;
    wait_cycles(1);
    check_output("mid_tx_level", q_tx_level, 1);
    apply_stimulus(4'h9);
    check_output("mid_no_push", q_rx_level, 0);
    csb = 1'b1;
    wait_cycles(4);
    check_output("mid_tx_flushed", q_tx_level, 0);
    check_output("mid_rx_level", q_rx_level, 0);
    check_output("mid_io_oe", q_io_oe, 0);
    csb = 1'b0;
    wait_cycles(4);
    send_byte(8'h3C);
    pop_check("mid_next", 8'h3C, 1'b1);
    csb = 1'b1;
    wait_cycles(4);

    $display("[TB] overflow");
    csb = 1'b0;
    wait_cycles(4);
    send_byte(8'h11);
    send_byte(8'h22);
    check_output("ovf_level2", q_rx_level, 2);
    check_output("ovf_rdy2", q_rdy, 1);
    send_byte(8'h33);
    check_output("ovf_level3", q_rx_level, 3);
    check_output("ovf_rdy3", q_rdy, 0);
    check_output("ovf_err3", q_err, 0);
    send_byte(8'h44);
    check_output("ovf_level4", q_rx_level, 4);
    check_output("ovf_err4", q_err, 0);
    send_byte(8'h55);
    check_output("ovf_err5", q_err, 1);
    check_output("ovf_level5", q_rx_level, 4);
    pop_check("ovf_b1", 8'h11, 1'b1);
    pop_check("ovf_b2", 8'h22, 1'b0);
    pop_check("ovf_b3", 8'h33, 1'b0);
    pop_check("ovf_b4", 8'h44, 1'b0);
    check_output("ovf_drained", q_rx_level, 0);
    check_output("ovf_err_sticky", q_err, 1);
    csb = 1'b1;
    wait_cycles(4);
    check_output("ovf_err_clear", q_err, 0);

    $display("[TB] full-FIFO push and pop");
    csb = 1'b0;
    wait_cycles(4);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    check_output("pp_full", q_rx_level, 4);
    apply_stimulus(4'hA);
    io = 4'h5;
    wait_cycles(3);
    bclk = 1'b1;
    @(negedge clock);
    q_din_ready = 1'b1;
    @(negedge clock);
    q_din_ready = 1'b0;
    wait_cycles(2);
    bclk = 1'b0;
    wait_cycles(4);
    check_output("pp_err", q_err, 0);
    check_output("pp_level", q_rx_level, 4);
    pop_check("pp_b2", 8'hA2, 1'b0);
    pop_check("pp_b3", 8'hA3, 1'b0);
    pop_check("pp_b4", 8'hA4, 1'b0);
    pop_check("pp_b5", 8'hA5, 1'b0);
    csb = 1'b1;
    wait_cycles(4);

    $display("[TB] reset mid-transaction");
    csb = 1'b0;
    wait_cycles(4);
    apply_stimulus(4'h6);
    resetn = 1'b0;
    wait_cycles(2);
    check_output("rmid_din_valid", q_din_valid, 0);
    check_output("rmid_din_data", q_din_data, 0);
    check_output("rmid_din_start", q_din_start, 0);
    check_output("rmid_rx_level", q_rx_level, 0);
    check_output("rmid_tx_level", q_tx_level, 0);
    check_output("rmid_rdy", q_rdy, 0);
    check_output("rmid_err", q_err, 0);
    check_output("rmid_dout_ready", q_dout_ready, 0);
    check_output("rmid_io_oe", q_io_oe, 0);
    check_output("rmid_io_do", q_io_do, 0);
    resetn = 1'b1;
    wait_cycles(4);
    apply_stimulus(4'h7);
    apply_stimulus(4'h8);
    apply_stimulus(4'h9);
    check_output("rmid_gated_valid", q_din_valid, 0);
    check_output("rmid_gated_level", q_rx_level, 0);
    check_output("rmid_gated_rdy", q_rdy, 0);
    csb = 1'b1;
    wait_cycles(4);
    csb = 1'b0;
    wait_cycles(4);
    send_byte(8'h42);
    pop_check("rmid_after", 8'h42, 1'b1);
    csb = 1'b1;
    wait_cycles(4);

    $display("[TB] SPI response");
    s_din_ready = 1'b0;
    check_output("spi_rx_empty", s_rx_level, 0);
    csb = 1'b0;
    wait_cycles(4);
    s_dout_data = 8'hA5; s_dout_valid = 1'b1;
    @(negedge clock);
    s_dout_valid = 1'b0;
    wait_cycles(1);
    check_output("spi_tx_level", s_tx_level, 1);
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      apply_stimulus({3'b000, pat[i]});
      check_output("spi_cmd_oe", s_oe_seen, 0);
    end
    check_output("spi_cmd_valid", s_din_valid, 1);
    check_output("spi_cmd_data", s_din_data, 8'h3C);
    check_output("spi_cmd_start", s_din_start, 1);
    check_output("spi_oe_on", s_io_oe, 1);
    check_output("spi_tx_popped", s_tx_level, 0);
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      apply_stimulus(4'h0);
      check_output("spi_resp_bit", s_do_seen, pat[i]);
      check_output("spi_resp_oe", s_oe_seen, 1);
    end
    check_output("spi_oe_off", s_io_oe, 0);
    csb = 1'b1;
    wait_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
